// File: rtl/r200_id_stage.sv
// r200_id_stage
//   Registered RV32 decode stage: register file with a WB->ID bypass,
//   immediate generation, control decode, a register scoreboard for
//   RAW/WAW interlocks, flush, and a saturating hazard-stall counter.
//   An instruction accepted from fetch appears in the ID/EX register on
//   the next clock edge.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid/in_ready        fetch handshake (in_ready is combinational)
//   in_instr, in_pc          instruction word and its PC
//   wb_we, wb_addr, wb_data  register writeback port
//   flush                    kill the ID/EX instruction, refuse input
//   out_valid/out_ready      execute handshake on the ID/EX register
//   out_pc .. out_illegal    registered decoded fields
//   stall_cnt                saturating count of hazard-stall cycles
module r200_id_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1v,
  output logic [XLEN-1:0] out_rs2v,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_alt,
  output logic            out_regwr,
  output logic            out_memwr,
  output logic            out_isload,
  output logic            out_illegal,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int AW = $clog2(NREG);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  // Registers x0 and anything at or beyond NREG do not physically exist.
  function automatic logic inRange(input logic [4:0] a);
    return (32'(a) < 32'(NREG));
  endfunction

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pendNext;
  logic [CNTW-1:0] r_stallCnt;

  logic            r_outValid, r_outAlt, r_outRegwr, r_outMemwr, r_outIsload, r_outIllegal;
  logic [XLEN-1:0] r_outPc, r_outRs1v, r_outRs2v, r_outImm;
  logic [4:0]      r_outRd;
  logic [6:0]      r_outOpcode;
  logic [2:0]      r_outFunct3;

  logic [6:0]      w_op;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic            w_use1, w_use2, w_writesRd, w_memwr, w_isload, w_illegal, w_regwr;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm, w_rs1v, w_rs2v;
  logic            w_byp1, w_byp2, w_pend1, w_pend2, w_pendRd;
  logic            w_hazard, w_ready, w_accept;

  assign w_op  = in_instr[6:0];
  assign w_rd  = in_instr[11:7];
  assign w_rs1 = in_instr[19:15];
  assign w_rs2 = in_instr[24:20];

  // Control decode and immediate selection by opcode.
  always_comb begin
    w_use1     = 1'b0;
    w_use2     = 1'b0;
    w_writesRd = 1'b0;
    w_memwr    = 1'b0;
    w_isload   = 1'b0;
    w_illegal  = 1'b0;
    w_imm32    = '0;
    case (w_op)
      OP_LUI, OP_AUIPC: begin
        w_writesRd = 1'b1;
        w_imm32    = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        w_writesRd = 1'b1;
        w_imm32    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_JALR, OP_OPIMM: begin
        w_use1     = 1'b1;
        w_writesRd = 1'b1;
        w_imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_LOAD: begin
        w_use1     = 1'b1;
        w_writesRd = 1'b1;
        w_isload   = 1'b1;
        w_imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_OP: begin
        w_use1     = 1'b1;
        w_use2     = 1'b1;
        w_writesRd = 1'b1;
      end
      OP_STORE: begin
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_memwr = 1'b1;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_regwr = w_writesRd & (w_rd != 5'd0);
  assign w_imm   = XLEN'(signed'(w_imm32));

  // A writeback to the register being read this cycle is forwarded so the
  // consumer does not have to wait for the regfile write to land.
  assign w_byp1 = wb_we & (wb_addr == w_rs1) & (w_rs1 != 5'd0);
  assign w_byp2 = wb_we & (wb_addr == w_rs2) & (w_rs2 != 5'd0);

  always_comb begin
    w_rs1v = '0;
    w_rs2v = '0;
    if (inRange(w_rs1) && w_rs1 != 5'd0)
      w_rs1v = w_byp1 ? wb_data : r_regs[w_rs1[AW-1:0]];
    if (inRange(w_rs2) && w_rs2 != 5'd0)
      w_rs2v = w_byp2 ? wb_data : r_regs[w_rs2[AW-1:0]];
  end

  assign w_pend1  = inRange(w_rs1) & r_pend[w_rs1[AW-1:0]];
  assign w_pend2  = inRange(w_rs2) & r_pend[w_rs2[AW-1:0]];
  assign w_pendRd = inRange(w_rd)  & r_pend[w_rd[AW-1:0]];

  assign w_hazard = in_valid & ((w_use1 & w_pend1 & ~w_byp1) |
                                (w_use2 & w_pend2 & ~w_byp2) |
                                (w_regwr & w_pendRd));
  assign w_ready  = ~rst & ~flush & ~w_hazard & (~r_outValid | out_ready);
  assign w_accept = in_valid & w_ready;
  assign in_ready = w_ready;

  // Scoreboard next state: clears first, so a set in the same cycle wins.
  always_comb begin
    w_pendNext = r_pend;
    if (wb_we && inRange(wb_addr))
      w_pendNext[wb_addr[AW-1:0]] = 1'b0;
    if (flush && r_outValid && r_outRegwr && inRange(r_outRd))
      w_pendNext[r_outRd[AW-1:0]] = 1'b0;
    if (w_accept && w_regwr && inRange(w_rd))
      w_pendNext[w_rd[AW-1:0]] = 1'b1;
  end

  // Register file and scoreboard state; x0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_pend <= '0;
    end else begin
      if (wb_we && inRange(wb_addr) && wb_addr != 5'd0)
        r_regs[wb_addr[AW-1:0]] <= wb_data;
      r_pend <= w_pendNext;
    end
  end

  // ID/EX register: load on accept, otherwise drop on flush or drain,
  // otherwise hold so execute sees stable fields under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid   <= 1'b0;
      r_outPc      <= '0;
      r_outRs1v    <= '0;
      r_outRs2v    <= '0;
      r_outImm     <= '0;
      r_outRd      <= '0;
      r_outOpcode  <= '0;
      r_outFunct3  <= '0;
      r_outAlt     <= 1'b0;
      r_outRegwr   <= 1'b0;
      r_outMemwr   <= 1'b0;
      r_outIsload  <= 1'b0;
      r_outIllegal <= 1'b0;
    end else if (w_accept) begin
      r_outValid   <= 1'b1;
      r_outPc      <= in_pc;
      r_outRs1v    <= w_rs1v;
      r_outRs2v    <= w_rs2v;
      r_outImm     <= w_imm;
      r_outRd      <= w_rd;
      r_outOpcode  <= w_op;
      r_outFunct3  <= in_instr[14:12];
      r_outAlt     <= in_instr[30];
      r_outRegwr   <= w_regwr;
      r_outMemwr   <= w_memwr;
      r_outIsload  <= w_isload;
      r_outIllegal <= w_illegal;
    end else if (flush || out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  // Only genuine hazard cycles are counted, not plain backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stallCnt <= '0;
    else if (in_valid && w_hazard && !flush && r_stallCnt != {CNTW{1'b1}})
      r_stallCnt <= r_stallCnt + 1'b1;
  end

  assign out_valid   = r_outValid;
  assign out_pc      = r_outPc;
  assign out_rs1v    = r_outRs1v;
  assign out_rs2v    = r_outRs2v;
  assign out_imm     = r_outImm;
  assign out_rd      = r_outRd;
  assign out_opcode  = r_outOpcode;
  assign out_funct3  = r_outFunct3;
  assign out_alt     = r_outAlt;
  assign out_regwr   = r_outRegwr;
  assign out_memwr   = r_outMemwr;
  assign out_isload  = r_outIsload;
  assign out_illegal = r_outIllegal;
  assign stall_cnt   = r_stallCnt;

endmodule

// File: tb/tb_r200_id_stage.sv
// tb_r200_id_stage
//   Drives r200_id_stage (RV32E-sized register file, 4-bit stall counter)
//   through directed scenarios followed by random traffic, comparing every
//   cycle against a behavioural model of the architectural state.
module tb_r200_id_stage;

  localparam int NREG_T = 16;
  localparam int CNTW_T = 4;
  localparam int SATMAX = 15;

  logic        clk, rst, in_valid, in_ready, wb_we, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, wb_data;
  logic [4:0]  wb_addr, out_rd;
  logic [31:0] out_pc, out_rs1v, out_rs2v, out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_alt, out_regwr, out_memwr, out_isload, out_illegal;
  logic [CNTW_T-1:0] stall_cnt;

  int checkCnt = 0;
  int passCnt  = 0;

  r200_id_stage #(.XLEN(32), .NREG(NREG_T), .CNTW(CNTW_T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rs1v(out_rs1v),
    .out_rs2v(out_rs2v), .out_imm(out_imm), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_alt(out_alt),
    .out_regwr(out_regwr), .out_memwr(out_memwr), .out_isload(out_isload),
    .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural registers, pending flags, the
  // contents of the ID/EX register and the stall counter.
  typedef struct {
    bit          valid;
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    bit          alt, regwr, memwr, isload, illegal;
  } outT;

  logic [31:0] mRegs [32];
  bit          mPend [32];
  outT         mOut;
  int          mStall;

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      mRegs[i] = '0;
      mPend[i] = 1'b0;
    end
    mOut   = '{default: '0};
    mStall = 0;
  endtask

  // Immediates computed as signed integers from the instruction fields.
  function automatic void refDecode(input logic [31:0] ins, output bit u1, output bit u2,
                                    output bit wr, output bit st, output bit ld,
                                    output bit ill, output logic [31:0] imm);
    longint f, v;
    u1 = 0; u2 = 0; wr = 0; st = 0; ld = 0; ill = 0; v = 0;
    case (ins[6:0])
      7'h37, 7'h17: begin wr = 1; f = ins[31:12]; v = f * 4096; end
      7'h6F: begin
        wr = 1; f = {ins[31], ins[19:12], ins[20], ins[30:21]};
        v = f * 2 - (ins[31] ? 2097152 : 0);
      end
      7'h67, 7'h13, 7'h03: begin
        u1 = 1; wr = 1; ld = (ins[6:0] == 7'h03);
        f = ins[31:20]; v = f - (ins[31] ? 4096 : 0);
      end
      7'h33: begin u1 = 1; u2 = 1; wr = 1; end
      7'h23: begin
        u1 = 1; u2 = 1; st = 1;
        f = {ins[31:25], ins[11:7]}; v = f - (ins[31] ? 4096 : 0);
      end
      7'h63: begin
        u1 = 1; u2 = 1;
        f = {ins[31], ins[7], ins[30:25], ins[11:8]};
        v = f * 2 - (ins[31] ? 8192 : 0);
      end
      default: ill = 1;
    endcase
    if (ins[11:7] == 5'd0) wr = 0;
    imm = v[31:0];
  endfunction

  function automatic logic [31:0] refRead(input int a);
    if (a == 0 || a >= NREG_T) return '0;
    if (wb_we && int'(wb_addr) == a) return wb_data;
    return mRegs[a];
  endfunction

  function automatic bit pendOf(input int a);
    return (a < NREG_T) ? mPend[a] : 1'b0;
  endfunction

  function automatic bit bypassed(input int a);
    return wb_we && int'(wb_addr) == a && a != 0;
  endfunction

  function automatic bit refHazard();
    bit u1, u2, wr, st, ld, ill;
    logic [31:0] imm;
    int rs1, rs2, rd;
    refDecode(in_instr, u1, u2, wr, st, ld, ill, imm);
    rs1 = int'(in_instr[19:15]);
    rs2 = int'(in_instr[24:20]);
    rd  = int'(in_instr[11:7]);
    return in_valid && ((u1 && pendOf(rs1) && !bypassed(rs1)) ||
                        (u2 && pendOf(rs2) && !bypassed(rs2)) ||
                        (wr && pendOf(rd)));
  endfunction

  function automatic bit refReady();
    return !rst && !flush && !refHazard() && (!mOut.valid || out_ready);
  endfunction

  // Advance the model by one clock edge using the inputs held across it.
  task automatic modelEdge();
    bit u1, u2, wr, st, ld, ill, hz, acc;
    logic [31:0] imm, v1, v2;
    int rd;
    refDecode(in_instr, u1, u2, wr, st, ld, ill, imm);
    rd  = int'(in_instr[11:7]);
    hz  = refHazard();
    acc = in_valid && refReady();
    v1  = refRead(int'(in_instr[19:15]));
    v2  = refRead(int'(in_instr[24:20]));
    if (wb_we) mPend[wb_addr] = 1'b0;
    if (flush && mOut.valid && mOut.regwr) mPend[mOut.rd] = 1'b0;
    if (acc && wr && rd < NREG_T) mPend[rd] = 1'b1;
    if (wb_we && wb_addr != 0 && int'(wb_addr) < NREG_T) mRegs[wb_addr] = wb_data;
    if (in_valid && hz && !flush && mStall < SATMAX) mStall++;
    if (acc) begin
      mOut.valid = 1; mOut.pc = in_pc; mOut.rs1v = v1; mOut.rs2v = v2;
      mOut.imm = imm; mOut.rd = in_instr[11:7]; mOut.opcode = in_instr[6:0];
      mOut.f3 = in_instr[14:12]; mOut.alt = in_instr[30]; mOut.regwr = wr;
      mOut.memwr = st; mOut.isload = ld; mOut.illegal = ill;
    end else if (flush || out_ready) begin
      mOut.valid = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkState();
    checkOutput("out_valid", out_valid, mOut.valid);
    if (mOut.valid) begin
      checkOutput("out_pc", out_pc, mOut.pc);
      checkOutput("out_rs1v", out_rs1v, mOut.rs1v);
      checkOutput("out_rs2v", out_rs2v, mOut.rs2v);
      checkOutput("out_imm", out_imm, mOut.imm);
      checkOutput("out_rd", out_rd, mOut.rd);
      checkOutput("out_opcode", out_opcode, mOut.opcode);
      checkOutput("out_funct3", out_funct3, mOut.f3);
      checkOutput("out_alt", out_alt, mOut.alt);
      checkOutput("out_regwr", out_regwr, mOut.regwr);
      checkOutput("out_memwr", out_memwr, mOut.memwr);
      checkOutput("out_isload", out_isload, mOut.isload);
      checkOutput("out_illegal", out_illegal, mOut.illegal);
    end
    checkOutput("stall_cnt", stall_cnt, mStall);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_pc"}, out_pc, 0);
    checkOutput({tag, "_imm"}, out_imm, 0);
    checkOutput({tag, "_rd"}, out_rd, 0);
    checkOutput({tag, "_regwr"}, out_regwr, 0);
    checkOutput({tag, "_stall"}, stall_cnt, 0);
  endtask

  // One clock: check in_ready just after the inputs settle, advance the
  // model at the rising edge, and check registered state on the falling edge.
  task automatic applyStimulus();
    #1;
    checkOutput("in_ready", in_ready, refReady());
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkState();
  endtask

  function automatic logic [4:0] randReg();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 11))
      0: ins[6:0] = 7'h37;  1: ins[6:0] = 7'h17;  2: ins[6:0] = 7'h6F;
      3: ins[6:0] = 7'h67;  4: ins[6:0] = 7'h03;  5: ins[6:0] = 7'h13;
      6: ins[6:0] = 7'h33;  7: ins[6:0] = 7'h23;  8: ins[6:0] = 7'h63;
      9: ins[6:0] = 7'h7F;  10: ins[6:0] = 7'h73; default: ins[6:0] = 7'h33;
    endcase
    ins[11:7]  = randReg();
    ins[19:15] = randReg();
    ins[24:20] = randReg();
    return ins;
  endfunction

  initial begin
    clk = 0; rst = 1; in_valid = 0; in_instr = '0; in_pc = '0;
    wb_we = 0; wb_addr = '0; wb_data = '0; flush = 0; out_ready = 1;
    modelReset();
    #2;
    checkCleared("reset");
    @(negedge clk);
    rst = 0;

    // ADDI x5,x0,-1 at 0x100 appears one cycle later.
    in_valid = 1; in_instr = 32'hFFF00293; in_pc = 32'h100;
    applyStimulus();
    checkOutput("t1_valid", out_valid, 1);
    checkOutput("t1_imm", out_imm, 32'hFFFFFFFF);
    checkOutput("t1_rd", out_rd, 5);
    checkOutput("t1_regwr", out_regwr, 1);
    checkOutput("t1_pc", out_pc, 32'h100);

    // ADD x6,x5,x5 waits on x5, then takes the bypassed writeback value.
    in_instr = 32'h00528333; in_pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("t2_ready", in_ready, 0);
      checkOutput("t2_stall", stall_cnt, i + 1);
    end
    wb_we = 1; wb_addr = 5; wb_data = 32'd7;
    applyStimulus();
    checkOutput("t2_rs1v", out_rs1v, 7);
    checkOutput("t2_rs2v", out_rs2v, 7);
    wb_we = 0;

    // LUI x1,0x12345 held by backpressure.
    in_instr = 32'h123450B7; in_pc = 32'h108;
    applyStimulus();
    out_ready = 0; in_instr = 32'h00100113; in_pc = 32'h10C;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("t3_imm", out_imm, 32'h12345000);
      checkOutput("t3_ready", in_ready, 0);
      checkOutput("t3_stall", stall_cnt, 3);
    end
    out_ready = 1; in_valid = 0;
    applyStimulus();

    // LW x8 flushed; ADD x9,x8,x8 then goes straight in.
    in_valid = 1; in_instr = 32'h00002403; in_pc = 32'h110;
    applyStimulus();
    in_valid = 0; flush = 1;
    applyStimulus();
    checkOutput("t4_flushed", out_valid, 0);
    flush = 0; in_valid = 1; in_instr = 32'h008404B3; in_pc = 32'h114;
    applyStimulus();
    checkOutput("t4_valid", out_valid, 1);
    checkOutput("t4_rd", out_rd, 9);
    checkOutput("t4_stall", stall_cnt, 3);

    // x20 does not exist with 16 registers; opcode 0x7F is illegal.
    in_instr = 32'h000A01B3; wb_we = 1; wb_addr = 20; wb_data = 32'hDEADBEEF;
    applyStimulus();
    checkOutput("t5_rs1v", out_rs1v, 0);
    checkOutput("t5_rd", out_rd, 3);
    wb_we = 0; in_instr = 32'h0000057F;
    applyStimulus();
    checkOutput("t5_illegal", out_illegal, 1);
    checkOutput("t5_regwr", out_regwr, 0);

    // Long stall saturates the counter, then async reset mid-stall.
    in_instr = 32'hFFF00293; in_pc = 32'h118;
    applyStimulus();
    out_ready = 0; in_instr = 32'h00528333;
    for (int i = 0; i < 16; i++) applyStimulus();
    checkOutput("sat_stall", stall_cnt, SATMAX);
    checkOutput("sat_valid", out_valid, 1);
    #2;
    rst = 1;
    #1;
    checkCleared("t6");
    modelReset();
    @(negedge clk);
    rst = 0; out_ready = 1;
    applyStimulus();
    checkOutput("t6_accept", out_valid, 1);
    checkOutput("t6_rs1v", out_rs1v, 0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 4) != 0);
      in_instr  = randInstr();
      in_pc     = {$urandom_range(0, 32'h3FFF), 2'b00};
      wb_we     = ($urandom_range(0, 2) == 0);
      wb_addr   = randReg();
      wb_data   = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
